// File: rtl/hornet_stack.sv
// hornet_stack: LIFO with circular/bounded modes; HORNET_STACK_FLAGS_EN adds sticky ovf/unf flags
module hornet_stack #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8,
  parameter int MODE  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 op,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  input  logic                       flag_clr,
  output logic                       ovf,
  output logic                       unf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_up;
  logic [AW-1:0] ptr_dn;
  logic is_push;
  logic is_pop;
  logic is_rep;
  logic do_push;
  logic do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign ptr_up  = ptr + 1'b1;
  assign ptr_dn  = ptr - 1'b1;
  assign is_push = op == 2'b01;
  assign is_pop  = op == 2'b10;
  assign is_rep  = op == 2'b11;
  // bounded mode drops a push at full or a pop at empty; circular mode never blocks
  assign do_push = is_push && !(MODE == 1 && full);
  assign do_pop  = is_pop && !(MODE == 1 && empty);
  // stack storage, top pointer, occupancy and registered top-of-stack
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      ptr         <= ptr_up;
      mem[ptr_up] <= din;
      q           <= din;
      count       <= full ? count : count + 1'b1;
    end else if (do_pop) begin
      ptr   <= ptr_dn;
      q     <= mem[ptr_dn];
      count <= empty ? count : count - 1'b1;
    end else if (is_rep) begin
      mem[ptr] <= din;
      q        <= din;
    end
  end
`ifdef HORNET_STACK_FLAGS_EN
  // sticky flags: a set event outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (is_push && full) ? 1'b1 : flag_clr ? 1'b0 : ovf;
      unf <= (is_pop && empty) ? 1'b1 : flag_clr ? 1'b0 : unf;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = flag_clr;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif
endmodule

// File: tb/tb_hornet_stack.sv
// tb_hornet_stack: directed vector table plus model scoreboard for circular and bounded instances
module tb_hornet_stack;
  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, REP = 2'b11;
`ifdef HORNET_STACK_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] op = NOP;
  logic [17:0] din = '0;
  logic flag_clr = 1'b0;
  logic [17:0] q0, q1;
  logic [3:0] c0, c1;
  logic f0, f1, e0, e1, o0, o1, u0, u1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hornet_stack #(.WIDTH(18), .DEPTH(8), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .din(din), .q(q0), .count(c0),
    .full(f0), .empty(e0), .flag_clr(flag_clr), .ovf(o0), .unf(u0));
  hornet_stack #(.WIDTH(18), .DEPTH(8), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .din(din), .q(q1), .count(c1),
    .full(f1), .empty(e1), .flag_clr(flag_clr), .ovf(o1), .unf(u1));

  typedef struct {
    logic [17:0] q;
    int c;
    bit o;
    bit u;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit rst;
    logic [1:0] op;
    logic [17:0] din;
    bit clr;
    logic [17:0] eq;
    int ec;
    bit eo;
    bit eu;
  } vec_t;
  vec_t tbl[$];

  logic [17:0] mm [2][8];
  int mp[2];
  int mc[2];
  logic [17:0] mq[2];
  bit mo[2];
  bit mu[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mstep(input int md, input bit r, input logic [1:0] o, input logic [17:0] d, input bit c);
    bit ev_o, ev_u;
    if (r) begin
      for (int i = 0; i < 8; i++) mm[md][i] = '0;
      mp[md] = 0; mc[md] = 0; mq[md] = '0; mo[md] = 0; mu[md] = 0;
      return;
    end
    ev_o = (o == PUSH) && (mc[md] == 8);
    ev_u = (o == POP) && (mc[md] == 0);
    if (o == PUSH && !(md == 1 && ev_o)) begin
      mp[md] = (mp[md] + 1) % 8;
      mm[md][mp[md]] = d;
      mq[md] = d;
      if (mc[md] < 8) mc[md]++;
    end else if (o == POP && !(md == 1 && ev_u)) begin
      mp[md] = (mp[md] + 7) % 8;
      mq[md] = mm[md][mp[md]];
      if (mc[md] > 0) mc[md]--;
    end else if (o == REP) begin
      mm[md][mp[md]] = d;
      mq[md] = d;
    end
    if (FL) begin
      mo[md] = ev_o | (mo[md] & !c);
      mu[md] = ev_u | (mu[md] & !c);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [17:0] q, input logic [3:0] c,
                     input logic f, input logic em, input logic o, input logic u);
    chk({tag, "_q"}, 32'(q), 32'(e.q));
    chk({tag, "_count"}, 32'(c), 32'(e.c));
    chk({tag, "_full"}, 32'(f), 32'(e.c == 8));
    chk({tag, "_empty"}, 32'(em), 32'(e.c == 0));
    chk({tag, "_ovf"}, 32'(o), 32'(e.o));
    chk({tag, "_unf"}, 32'(u), 32'(e.u));
  endtask

  // drive one cycle: model predicts into the scoreboard, DUT outputs compared #1 after the edge
  task automatic step(input bit r, input logic [1:0] o, input logic [17:0] d, input bit c);
    exp_t e;
    reset = r; op = o; din = d; flag_clr = c;
    for (int m = 0; m < 2; m++) begin
      mstep(m, r, o, d, c);
      e.q = mq[m]; e.c = mc[m]; e.o = mo[m]; e.u = mu[m];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; op = NOP; flag_clr = 1'b0;
    if (sb.size() < 2) begin
      chk("scoreboard_underrun", 32'(sb.size()), 32'd2);
    end else begin
      cmp("m0", sb.pop_front(), q0, c0, f0, e0, o0, u0);
      cmp("m1", sb.pop_front(), q1, c1, f1, e1, o1, u1);
    end
  endtask

  task automatic add(input bit r, input logic [1:0] o, input logic [17:0] d, input bit c,
                     input logic [17:0] eq, input int ec, input bit eo, input bit eu);
    vec_t v;
    v.rst = r; v.op = o; v.din = d; v.clr = c; v.eq = eq; v.ec = ec; v.eo = eo; v.eu = eu;
    tbl.push_back(v);
  endtask

  initial begin
    int pq[7];
    pq = '{8, 7, 6, 5, 4, 3, 2};
    add(1, NOP, 0, 0, 0, 0, 0, 0);
    add(0, PUSH, 1, 0, 1, 1, 0, 0);
    add(0, PUSH, 2, 0, 2, 2, 0, 0);
    add(0, PUSH, 3, 0, 3, 3, 0, 0);
    add(0, POP, 0, 0, 2, 2, 0, 0);
    add(0, POP, 0, 0, 1, 1, 0, 0);
    add(1, NOP, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add(0, PUSH, 18'(i), 0, 18'(i), i > 8 ? 8 : i, i == 9, 0);
    for (int i = 0; i < 7; i++) add(0, POP, 0, 0, 18'(pq[i]), 7 - i, 1, 0);
    add(0, POP, 0, 0, 9, 0, 1, 0);
    add(0, POP, 0, 0, 8, 0, 1, 1);
    add(0, NOP, 0, 1, 8, 0, 0, 0);
    add(0, REP, 18'h3FFFF, 0, 18'h3FFFF, 0, 0, 0);
    add(0, PUSH, 5, 0, 5, 1, 0, 0);
    add(0, POP, 0, 0, 18'h3FFFF, 0, 0, 0);
    add(1, NOP, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(0, PUSH, 18'(i), 0, 18'(i), i, 0, 0);
    add(0, PUSH, 9, 0, 9, 8, 1, 0);
    add(0, PUSH, 10, 1, 10, 8, 1, 0);
    add(0, NOP, 0, 1, 10, 8, 0, 0);
    add(1, NOP, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(0, PUSH, 18'(i), 0, 18'(i), i, 0, 0);
    add(1, PUSH, 7, 0, 0, 0, 0, 0);
    add(0, NOP, 0, 0, 0, 0, 0, 0);
    add(0, PUSH, 18'h2A, 0, 18'h2A, 1, 0, 0);
    add(0, POP, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].op, tbl[k].din, tbl[k].clr);
      chk($sformatf("vec%0d_q", k), 32'(q0), 32'(tbl[k].eq));
      chk($sformatf("vec%0d_count", k), 32'(c0), 32'(tbl[k].ec));
      chk($sformatf("vec%0d_full", k), 32'(f0), 32'(tbl[k].ec == 8));
      chk($sformatf("vec%0d_empty", k), 32'(e0), 32'(tbl[k].ec == 0));
      chk($sformatf("vec%0d_ovf", k), 32'(o0), 32'(tbl[k].eo & FL));
      chk($sformatf("vec%0d_unf", k), 32'(u0), 32'(tbl[k].eu & FL));
    end

    // bounded instance: ninth push dropped, pop at empty leaves q alone
    step(1, NOP, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, PUSH, 18'(i), 0);
    chk("bounded_full_q", 32'(q1), 32'h8);
    chk("bounded_full_count", 32'(c1), 32'd8);
    chk("bounded_full_ovf", 32'(o1), 32'(FL));
    for (int i = 0; i < 8; i++) step(0, POP, 0, 0);
    step(0, REP, 18'h155, 0);
    step(0, POP, 0, 0);
    chk("bounded_empty_q", 32'(q1), 32'h155);
    chk("bounded_empty_count", 32'(c1), 32'd0);
    chk("bounded_empty_unf", 32'(u1), 32'(FL));

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)), 18'($urandom), $urandom_range(0, 7) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
